// File: rtl/bht_ctrl_if.sv
// bht_ctrl_if: fetch/execute-side bundle for the branch history table controller.
interface bht_ctrl_if #(
  parameter int INDEX_BITS = 6,
  parameter int CNT_W      = 16
);
  logic                  flush;
  logic                  ready;
  logic                  lk_valid;
  logic [INDEX_BITS-1:0] lk_index;
  logic                  lk_resp_valid;
  logic                  lk_taken;
  logic [1:0]            lk_state;
  logic                  up_valid;
  logic [INDEX_BITS-1:0] up_index;
  logic                  up_taken;
  logic                  mispredict;
  logic [CNT_W-1:0]      mispred_cnt;
  modport master (
    output flush, lk_valid, lk_index, up_valid, up_index, up_taken,
    input  ready, lk_resp_valid, lk_taken, lk_state, mispredict, mispred_cnt
  );
  modport slave (
    input  flush, lk_valid, lk_index, up_valid, up_index, up_taken,
    output ready, lk_resp_valid, lk_taken, lk_state, mispredict, mispred_cnt
  );
endinterface

// File: rtl/bht_ctrl.sv
// bht_ctrl: table of 2-bit saturating branch counters with registered lookup,
// resolved-outcome updates, a mispredict counter and an init sweep FSM.
module bht_ctrl #(
  parameter int         INDEX_BITS = 6,
  parameter logic [1:0] INIT_STATE = 2'b01,
  parameter int         CNT_W      = 16
) (
  input logic       clk,
  input logic       rst,
  bht_ctrl_if.slave bus
);
  typedef enum logic {INIT, RUN} state_e;
  localparam logic [INDEX_BITS-1:0] LAST = '1;
  state_e                state_q, state_d;
  logic [INDEX_BITS-1:0] ptr_q, ptr_d;
  logic [1:0]            tbl_q [2**INDEX_BITS];
  logic [1:0]            up_old, up_new, lk_val;
  logic                  run, up_en, lk_en, mis;
  logic                  lk_resp_valid_q, mispredict_q;
  logic [1:0]            lk_state_q;
  logic [CNT_W-1:0]      cnt_q;
  always_comb begin
    run     = state_q == RUN;
    up_en   = run && !rst && bus.up_valid && !bus.flush;
    lk_en   = run && bus.lk_valid && !bus.flush;
    up_old  = tbl_q[bus.up_index];
    up_new  = bus.up_taken ? (up_old == 2'b11 ? up_old : up_old + 2'd1)
                           : (up_old == 2'b00 ? up_old : up_old - 2'd1);
    mis     = up_en && (bus.up_taken != up_old[1]);
    // write-first bypass so a same-cycle lookup sees the updated counter
    lk_val  = (up_en && bus.up_index == bus.lk_index) ? up_new : tbl_q[bus.lk_index];
    state_d = run ? (bus.flush ? INIT : RUN) : (ptr_q == LAST ? RUN : INIT);
    ptr_d   = run ? '0 : ptr_q + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (!run) tbl_q[ptr_q] <= INIT_STATE;
    else if (up_en) tbl_q[bus.up_index] <= up_new;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= INIT;
      ptr_q           <= '0;
      lk_resp_valid_q <= 1'b0;
      lk_state_q      <= 2'b00;
      mispredict_q    <= 1'b0;
      cnt_q           <= '0;
    end else begin
      state_q         <= state_d;
      ptr_q           <= ptr_d;
      lk_resp_valid_q <= lk_en;
      lk_state_q      <= lk_en ? lk_val : lk_state_q;
      mispredict_q    <= mis;
      cnt_q           <= (mis && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    end
  end
  assign bus.ready         = run;
  assign bus.lk_resp_valid = lk_resp_valid_q;
  assign bus.lk_state      = lk_state_q;
  assign bus.lk_taken      = lk_state_q[1];
  assign bus.mispredict    = mispredict_q;
  assign bus.mispred_cnt   = cnt_q;
endmodule

// File: tb/tb_bht_ctrl.sv
// tb_bht_ctrl: directed stimulus with queued expectations; a monitor checks
// lookup responses and mispredict pulses as the DUT presents them.
module tb_bht_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  bht_ctrl_if #(.INDEX_BITS(6), .CNT_W(16)) bus ();
  bht_ctrl_if #(.INDEX_BITS(2), .CNT_W(2))  sb ();
  bht_ctrl #(.INDEX_BITS(6), .INIT_STATE(2'b01), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  bht_ctrl #(.INDEX_BITS(2), .INIT_STATE(2'b01), .CNT_W(2))  dut_s (.clk(clk), .rst(rst), .bus(sb));
  int n_cmp = 0;
  int n_bad = 0;
  logic [1:0]  lk_q [$];
  logic [15:0] mis_q [$];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic lookup(input logic [5:0] idx, input logic [1:0] exp);
    bus.lk_valid = 1'b1;
    bus.lk_index = idx;
    lk_q.push_back(exp);
    tick();
    bus.lk_valid = 1'b0;
  endtask
  task automatic update(input logic [5:0] idx, input logic tk, input logic exp_mis, input logic [15:0] exp_cnt);
    bus.up_valid = 1'b1;
    bus.up_index = idx;
    bus.up_taken = tk;
    if (exp_mis) mis_q.push_back(exp_cnt);
    tick();
    bus.up_valid = 1'b0;
  endtask
  task automatic wait_ready(input string name, input int exp);
    int cyc = 0;
    while (!bus.ready && cyc < 200) begin
      tick();
      cyc++;
    end
    check(name, cyc, exp);
  endtask
  always @(negedge clk) begin
    if (bus.lk_resp_valid) begin
      if (lk_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL lk_unexpected: got response state %0h expected none at %0t", bus.lk_state, $time);
      end else begin
        logic [1:0] e;
        e = lk_q.pop_front();
        check("lk_state", bus.lk_state, e);
        check("lk_taken", bus.lk_taken, e[1]);
      end
    end
    if (bus.mispredict) begin
      if (mis_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL mis_unexpected: got mispredict cnt %0h expected none at %0t", bus.mispred_cnt, $time);
      end else check("mispred_cnt", bus.mispred_cnt, mis_q.pop_front());
    end
  end
  initial begin
    rst = 1'b1;
    {bus.flush, bus.lk_valid, bus.lk_index, bus.up_valid, bus.up_index, bus.up_taken} = '0;
    {sb.flush, sb.lk_valid, sb.lk_index, sb.up_valid, sb.up_index, sb.up_taken} = '0;
    tick();
    tick();
    check("rst_ready", bus.ready, 0);
    check("rst_lk_resp_valid", bus.lk_resp_valid, 0);
    check("rst_lk_state", bus.lk_state, 0);
    check("rst_mispredict", bus.mispredict, 0);
    check("rst_cnt", bus.mispred_cnt, 0);
    rst = 1'b0;
    wait_ready("init_sweep_cycles", 64);
    lookup(6'd0, 2'b01);
    lookup(6'd63, 2'b01);
    update(6'd5, 1'b1, 1'b1, 16'd1);
    update(6'd5, 1'b1, 1'b0, 16'd0);
    update(6'd5, 1'b1, 1'b0, 16'd0);
    lookup(6'd5, 2'b11);
    update(6'd5, 1'b1, 1'b0, 16'd0);
    lookup(6'd5, 2'b11);
    update(6'd5, 1'b0, 1'b1, 16'd2);
    lookup(6'd5, 2'b10);
    update(6'd5, 1'b0, 1'b1, 16'd3);
    lookup(6'd5, 2'b01);
    update(6'd7, 1'b0, 1'b0, 16'd0);
    update(6'd7, 1'b0, 1'b0, 16'd0);
    lookup(6'd7, 2'b00);
    bus.lk_valid = 1'b1;
    bus.lk_index = 6'd9;
    lk_q.push_back(2'b10);
    update(6'd9, 1'b1, 1'b1, 16'd4);
    bus.lk_valid = 1'b0;
    tick();
    check("cnt_before_flush", bus.mispred_cnt, 4);
    bus.flush = 1'b1;
    bus.up_valid = 1'b1;
    bus.up_index = 6'd9;
    bus.up_taken = 1'b1;
    tick();
    {bus.flush, bus.up_valid} = '0;
    check("flush_ready_low", bus.ready, 0);
    bus.lk_valid = 1'b1;
    bus.lk_index = 6'd9;
    wait_ready("flush_sweep_cycles", 64);
    bus.lk_valid = 1'b0;
    lookup(6'd9, 2'b01);
    lookup(6'd5, 2'b01);
    lookup(6'd7, 2'b01);
    tick();
    check("cnt_kept_over_flush", bus.mispred_cnt, 4);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    repeat (29) tick();
    check("mid_sweep_ready", bus.ready, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_sweep_cnt", bus.mispred_cnt, 0);
    wait_ready("restart_sweep_cycles", 64);
    lookup(6'd63, 2'b01);
    sb.up_valid = 1'b1;
    sb.up_index = 2'd1;
    for (int i = 0; i < 5; i++) begin
      sb.up_taken = (i % 2 == 0);
      tick();
      check("sat_mispredict", sb.mispredict, 1);
      check("sat_cnt", sb.mispred_cnt, (i < 3) ? i + 1 : 3);
    end
    sb.up_valid = 1'b0;
    repeat (3) tick();
    check("lk_queue_drained", lk_q.size(), 0);
    check("mis_queue_drained", mis_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
